cache_miss_ctrl: RTL and testbench

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

---
 rtl/cache_miss_ctrl.sv | 156 +++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: runs lookup, optional dirty-victim writeback and line
// refill for one CPU request at a time, strobing the replacement policy.
`timescale 1ns/1ps
module cache_miss_ctrl #(
  parameter  int unsigned SETS       = 128,
  parameter  int unsigned WAYS       = 2,
  parameter  int unsigned LINE_WORDS = 4,
  parameter  int unsigned ADDR_W     = 32,
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS) + 2,
  localparam int unsigned IDX_W      = $clog2(SETS),
  localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFF_W,
  localparam int unsigned WAY_W      = $clog2(WAYS),
  localparam int unsigned CNT_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  input  logic              lookup_hit_i,
  input  logic [WAY_W-1:0]  lookup_way_i,
  input  logic [WAY_W-1:0]  victim_way_i,
  input  logic              victim_dirty_i,
  input  logic [TAG_W-1:0]  victim_tag_i,
  output logic [IDX_W-1:0]  set_index_o,
  output logic              pol_hit_o,
  output logic              pol_miss_o,
  output logic              pol_fill_o,
  output logic [WAY_W-1:0]  pol_way_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_wvalid_o,
  input  logic              mem_wready_i,
  input  logic              mem_rvalid_i,
  output logic              fill_we_o,
  output logic [WAY_W-1:0]  fill_way_o,
  output logic [CNT_W-1:0]  fill_word_o,
  output logic              resp_valid_o,
  output logic              resp_hit_o
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA, DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [ADDR_W-OFF_W-1:0]   r_line;
  logic [WAY_W-1:0]          r_vway;
  logic [TAG_W-1:0]          r_vtag;
  logic                      r_hit;
  logic [CNT_W-1:0]          r_cnt;
  logic                      w_last;

  assign w_last      = (r_cnt == CNT_W'(LINE_WORDS - 1));
  assign set_index_o = r_line[IDX_W-1:0];

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next state and per-state outputs
  always_comb begin
    w_next          = r_state;
    req_ready_o     = 1'b0;
    pol_hit_o       = 1'b0;
    pol_miss_o      = 1'b0;
    pol_fill_o      = 1'b0;
    pol_way_o       = '0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_wvalid_o    = 1'b0;
    fill_we_o       = 1'b0;
    fill_way_o      = '0;
    fill_word_o     = '0;
    resp_valid_o    = 1'b0;
    resp_hit_o      = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_next = LOOKUP;
      end
      LOOKUP: begin
        if (lookup_hit_i) begin
          pol_hit_o = 1'b1;
          pol_way_o = lookup_way_i;
          w_next    = DONE;
        end else begin
          pol_miss_o = 1'b1;
          w_next     = victim_dirty_i ? WB_REQ : RF_REQ;
        end
      end
      WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = {r_vtag, r_line[IDX_W-1:0], OFF_W'(0)};
        if (mem_req_ready_i) w_next = WB_DATA;
      end
      WB_DATA: begin
        mem_wvalid_o = 1'b1;
        fill_way_o   = r_vway;
        fill_word_o  = r_cnt;
        if (mem_wready_i && w_last) w_next = RF_REQ;
      end
      RF_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {r_line, OFF_W'(0)};
        if (mem_req_ready_i) w_next = RF_DATA;
      end
      RF_DATA: begin
        fill_we_o   = mem_rvalid_i;
        fill_way_o  = r_vway;
        fill_word_o = r_cnt;
        if (mem_rvalid_i && w_last) begin
          pol_fill_o = 1'b1;
          pol_way_o  = r_vway;
          w_next     = DONE;
        end
      end
      DONE: begin
        resp_valid_o = 1'b1;
        resp_hit_o   = r_hit;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latch, victim latch and beat counter (wraps at line end)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_line <= '0;
      r_vway <= '0;
      r_vtag <= '0;
      r_hit  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (r_state == IDLE && req_valid_i) r_line <= req_addr_i[ADDR_W-1:OFF_W];
      if (r_state == LOOKUP) begin
        r_hit <= lookup_hit_i;
        if (!lookup_hit_i) begin
          r_vway <= victim_way_i;
          r_vtag <= victim_tag_i;
        end
      end
      if ((r_state == WB_DATA && mem_wready_i) || (r_state == RF_DATA && mem_rvalid_i))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: directed scenarios plus randomized
// requests checked against address arithmetic and per-request event totals.
`timescale 1ns/1ps
module tb_cache_miss_ctrl;

  localparam int unsigned SETS       = 128;
  localparam int unsigned WAYS       = 2;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS) + 2;
  localparam int unsigned IDX_W      = $clog2(SETS);
  localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WAY_W      = $clog2(WAYS);
  localparam int unsigned CNT_W      = $clog2(LINE_WORDS);

  logic              clk;
  logic              rst_ni;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready_o;
  logic              lookup_hit;
  logic [WAY_W-1:0]  lookup_way;
  logic [WAY_W-1:0]  victim_way;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic [IDX_W-1:0]  set_index_o;
  logic              pol_hit_o, pol_miss_o, pol_fill_o;
  logic [WAY_W-1:0]  pol_way_o;
  logic              mem_req_valid_o;
  logic              mem_req_ready;
  logic              mem_req_we_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_wvalid_o;
  logic              mem_wready;
  logic              mem_rvalid;
  logic              fill_we_o;
  logic [WAY_W-1:0]  fill_way_o;
  logic [CNT_W-1:0]  fill_word_o;
  logic              resp_valid_o;
  logic              resp_hit_o;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_hit = 0, exp_miss = 0, exp_fill = 0, exp_fillwe = 0, exp_resp = 0;
  int cnt_hit = 0, cnt_miss = 0, cnt_fill = 0, cnt_fillwe = 0, cnt_resp = 0, cnt_multi = 0;

  cache_miss_ctrl #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready_o),
    .lookup_hit_i(lookup_hit), .lookup_way_i(lookup_way),
    .victim_way_i(victim_way), .victim_dirty_i(victim_dirty), .victim_tag_i(victim_tag),
    .set_index_o(set_index_o),
    .pol_hit_o(pol_hit_o), .pol_miss_o(pol_miss_o), .pol_fill_o(pol_fill_o), .pol_way_o(pol_way_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready), .mem_rvalid_i(mem_rvalid),
    .fill_we_o(fill_we_o), .fill_way_o(fill_way_o), .fill_word_o(fill_word_o),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Event totals over the whole run, compared with the model at the end
  always @(negedge clk) begin
    if (rst_ni) begin
      if (pol_hit_o)    cnt_hit    <= cnt_hit + 1;
      if (pol_miss_o)   cnt_miss   <= cnt_miss + 1;
      if (pol_fill_o)   cnt_fill   <= cnt_fill + 1;
      if (fill_we_o)    cnt_fillwe <= cnt_fillwe + 1;
      if (resp_valid_o) cnt_resp   <= cnt_resp + 1;
      if ((32'(pol_hit_o) + 32'(pol_miss_o) + 32'(pol_fill_o)) > 32'd1) cnt_multi <= cnt_multi + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned set_of(input logic [ADDR_W-1:0] a);
    return (a / LINE_BYTES) % SETS;
  endfunction

  function automatic logic [ADDR_W-1:0] rf_addr(input logic [ADDR_W-1:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic logic [ADDR_W-1:0] wb_addr(input logic [TAG_W-1:0] t, input int unsigned s);
    return ADDR_W'(32'(t) * (SETS * LINE_BYTES) + s * LINE_BYTES);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory request phase: ready held low for 'stall' cycles, request must stay stable
  task automatic mem_phase(input bit we, input logic [ADDR_W-1:0] exp_addr, input int stall);
    for (int i = 0; i <= stall; i++) begin
      mem_req_ready = (i == stall);
      mem_rvalid    = 1'($urandom);
      mem_wready    = 1'($urandom);
      @(negedge clk);
      check("mreq_valid", 64'(mem_req_valid_o), 64'(1));
      check("mreq_we", 64'(mem_req_we_o), 64'(we));
      check("mreq_addr", 64'(mem_req_addr_o), 64'(exp_addr));
      check("mreq_fill_we", 64'(fill_we_o), 64'(0));
      tick();
    end
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_wready    = 1'b0;
  endtask

  // Line data phase; the off-direction strobe is randomized since it must be ignored
  task automatic beats(input bit wr, input logic [WAY_W-1:0] way, input int gapmax);
    int  gap;
    bit  fire;
    for (int w = 0; w < int'(LINE_WORDS); w++) begin
      gap = (gapmax == 0) ? 0 : int'($urandom_range(32'(gapmax), 1));
      for (int g = 0; g <= gap; g++) begin
        fire = (g == gap);
        if (wr) begin mem_wready = fire; mem_rvalid = 1'($urandom); end
        else    begin mem_rvalid = fire; mem_wready = 1'($urandom); end
        mem_req_ready = 1'($urandom);
        @(negedge clk);
        check("beat_word", 64'(fill_word_o), 64'(w));
        check("beat_way", 64'(fill_way_o), 64'(way));
        check("beat_mreq", 64'(mem_req_valid_o), 64'(0));
        if (wr) begin
          check("wb_wvalid", 64'(mem_wvalid_o), 64'(1));
          check("wb_fill_we", 64'(fill_we_o), 64'(0));
        end else begin
          check("rf_fill_we", 64'(fill_we_o), 64'(fire));
          check("rf_wvalid", 64'(mem_wvalid_o), 64'(0));
          check("rf_pol_fill", 64'(pol_fill_o), 64'(fire && w == int'(LINE_WORDS) - 1));
          if (fire && w == int'(LINE_WORDS) - 1) check("rf_pol_way", 64'(pol_way_o), 64'(way));
        end
        tick();
      end
    end
    mem_wready    = 1'b0;
    mem_rvalid    = 1'b0;
    mem_req_ready = 1'b0;
  endtask

  // One complete request from IDLE back to IDLE
  task automatic do_req(input logic [ADDR_W-1:0] a, input bit hit, input logic [WAY_W-1:0] lway,
                        input logic [WAY_W-1:0] vway, input bit dirty, input logic [TAG_W-1:0] vtag,
                        input int stall, input int gapmax);
    req_valid  = 1'b1;
    req_addr   = a;
    lookup_hit = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(req_ready_o), 64'(1));
    tick();
    req_valid    = 1'b0;
    req_addr     = $urandom;
    lookup_hit   = hit;
    lookup_way   = lway;
    victim_way   = vway;
    victim_dirty = dirty;
    victim_tag   = vtag;
    @(negedge clk);
    check("lk_set", 64'(set_index_o), 64'(set_of(a)));
    check("lk_ready", 64'(req_ready_o), 64'(0));
    check("lk_pol_hit", 64'(pol_hit_o), 64'(hit));
    check("lk_pol_miss", 64'(pol_miss_o), 64'(!hit));
    check("lk_resp", 64'(resp_valid_o), 64'(0));
    if (hit) check("lk_pol_way", 64'(pol_way_o), 64'(lway));
    tick();
    lookup_hit   = 1'($urandom);
    lookup_way   = WAY_W'($urandom);
    victim_way   = WAY_W'($urandom);
    victim_dirty = 1'($urandom);
    victim_tag   = TAG_W'($urandom);
    if (hit) exp_hit++;
    else begin
      exp_miss++;
      exp_fill++;
      exp_fillwe += int'(LINE_WORDS);
      if (dirty) begin
        mem_phase(1'b1, wb_addr(vtag, set_of(a)), stall);
        beats(1'b1, vway, gapmax);
      end
      mem_phase(1'b0, rf_addr(a), stall);
      beats(1'b0, vway, gapmax);
    end
    @(negedge clk);
    check("done_resp_valid", 64'(resp_valid_o), 64'(1));
    check("done_resp_hit", 64'(resp_hit_o), 64'(hit));
    check("done_ready", 64'(req_ready_o), 64'(0));
    check("done_set", 64'(set_index_o), 64'(set_of(a)));
    check("done_mreq", 64'(mem_req_valid_o), 64'(0));
    exp_resp++;
    tick();
    @(negedge clk);
    check("post_ready", 64'(req_ready_o), 64'(1));
    check("post_resp", 64'(resp_valid_o), 64'(0));
    tick();
  endtask

  initial begin
    logic [ADDR_W-1:0] a1, a2;
    rst_ni = 1'b0; req_valid = 1'b0; req_addr = '0; lookup_hit = 1'b0; lookup_way = '0;
    victim_way = '0; victim_dirty = 1'b0; victim_tag = '0; mem_req_ready = 1'b0;
    mem_wready = 1'b0; mem_rvalid = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_ready", 64'(req_ready_o), 64'(1));
    check("rst_set", 64'(set_index_o), 64'(0));
    check("rst_mreq", 64'(mem_req_valid_o), 64'(0));
    check("rst_resp", 64'(resp_valid_o), 64'(0));
    check("rst_word", 64'(fill_word_o), 64'(0));
    rst_ni = 1'b1;
    tick();

    // Hit, clean miss, dirty miss, backpressured miss
    do_req(32'h0000_1230, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 0);
    do_req(32'h0000_1230, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 0);
    do_req(32'h0000_1230, 1'b0, 1'b0, 1'b1, 1'b1, TAG_W'(5), 0, 0);
    do_req(32'h0000_1230, 1'b0, 1'b0, 1'b1, 1'b0, '0, 5, 3);
    do_req(32'hDEAD_BEEC, 1'b0, 1'b0, 1'b0, 1'b1, TAG_W'(21'h1ABCD), 5, 3);

    // Back-to-back with req_valid held high; second address must not leak into the first
    a1 = 32'h0000_0470; a2 = 32'h0000_07F0;
    req_valid = 1'b1; req_addr = a1;
    @(negedge clk);
    check("b2b_ready0", 64'(req_ready_o), 64'(1));
    tick();
    req_addr = a2; lookup_hit = 1'b1; lookup_way = 1'b0;
    @(negedge clk);
    check("b2b_lk_ready", 64'(req_ready_o), 64'(0));
    check("b2b_lk_set", 64'(set_index_o), 64'(set_of(a1)));
    check("b2b_lk_hit", 64'(pol_hit_o), 64'(1));
    tick();
    lookup_hit = 1'b0;
    @(negedge clk);
    check("b2b_done_ready", 64'(req_ready_o), 64'(0));
    check("b2b_done_resp", 64'(resp_valid_o), 64'(1));
    check("b2b_done_set", 64'(set_index_o), 64'(set_of(a1)));
    tick();
    @(negedge clk);
    check("b2b_idle_ready", 64'(req_ready_o), 64'(1));
    tick();
    req_valid = 1'b0; lookup_hit = 1'b1; lookup_way = 1'b1;
    @(negedge clk);
    check("b2b_lk2_set", 64'(set_index_o), 64'(set_of(a2)));
    check("b2b_lk2_hit", 64'(pol_hit_o), 64'(1));
    check("b2b_lk2_way", 64'(pol_way_o), 64'(1));
    tick();
    lookup_hit = 1'b0;
    @(negedge clk);
    check("b2b_done2_resp", 64'(resp_valid_o), 64'(1));
    check("b2b_done2_hit", 64'(resp_hit_o), 64'(1));
    tick();
    exp_hit += 2; exp_resp += 2;
    mem_rvalid = 1'b1; mem_wready = 1'b1;
    @(negedge clk);
    check("idle_spur_fill_we", 64'(fill_we_o), 64'(0));
    check("idle_spur_wvalid", 64'(mem_wvalid_o), 64'(0));
    check("idle_spur_ready", 64'(req_ready_o), 64'(1));
    tick();
    mem_rvalid = 1'b0; mem_wready = 1'b0;

    // Reset during refill after two beats
    req_valid = 1'b1; req_addr = 32'h0000_1230;
    tick();
    req_valid = 1'b0; lookup_hit = 1'b0; victim_dirty = 1'b0; victim_way = 1'b1;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rvalid = 1'b1;
    tick();
    tick();
    exp_miss++; exp_fillwe += 2;
    rst_ni = 1'b0;
    #1;
    check("arst_ready", 64'(req_ready_o), 64'(1));
    check("arst_fill_we", 64'(fill_we_o), 64'(0));
    check("arst_pol_fill", 64'(pol_fill_o), 64'(0));
    check("arst_resp", 64'(resp_valid_o), 64'(0));
    check("arst_word", 64'(fill_word_o), 64'(0));
    check("arst_set", 64'(set_index_o), 64'(0));
    @(negedge clk);
    #1;
    rst_ni = 1'b1; mem_rvalid = 1'b0;
    tick();
    @(negedge clk);
    check("arst_after_ready", 64'(req_ready_o), 64'(1));
    check("arst_after_resp", 64'(resp_valid_o), 64'(0));
    tick();
    do_req(32'h0000_1230, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1, 1);

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      do_req($urandom, 1'($urandom), WAY_W'($urandom), WAY_W'($urandom), 1'($urandom),
             TAG_W'($urandom), int'($urandom_range(4, 0)), int'($urandom_range(3, 0)));
    end

    tick(); tick();
    check("tot_pol_hit", 64'(cnt_hit), 64'(exp_hit));
    check("tot_pol_miss", 64'(cnt_miss), 64'(exp_miss));
    check("tot_pol_fill", 64'(cnt_fill), 64'(exp_fill));
    check("tot_fill_we", 64'(cnt_fillwe), 64'(exp_fillwe));
    check("tot_resp", 64'(cnt_resp), 64'(exp_resp));
    check("tot_pol_overlap", 64'(cnt_multi), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
